// File: rtl/gfx_pkg.sv
// Graphics-controller constants shared by the sprite ROM path.
package gfx_pkg;

  localparam int SPRITE_ADDR_W  = 14;
  localparam int SPRITE_DATA_W  = 8;
  localparam int SPRITE_ROM_LAT = 2;

  typedef logic [SPRITE_ADDR_W-1:0] sprite_addr_t;
  typedef logic [SPRITE_DATA_W-1:0] sprite_data_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: the first requester after i_last (wrapping) wins.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt
);

  logic          w_found;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IW'((int'(i_last) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares the single-port sprite ROM between N_REQ fetchers: round-robin grant with
// bounded burst lock, and a grant-tagged response pipeline matching the ROM latency.
module sprite_rom_arbiter
  import gfx_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = SPRITE_ADDR_W,
  parameter int DATA_W    = SPRITE_DATA_W,
  parameter int ROM_LAT   = SPRITE_ROM_LAT,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [IW-1:0]    r_last;
  logic [CW-1:0]    r_burst_cnt;
  logic             r_lock_vld;
  logic [N_REQ-1:0] r_pipe [ROM_LAT];

  logic [N_REQ-1:0] w_pick;
  logic             w_lock_hit;
  logic [IW-1:0]    w_win_idx;
  logic             w_any;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .i_req  (req),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );

  // Handshake: req[i] with req_addr held stable until the cycle gnt[i]=1, which is
  // the accept; the response returns on rsp_valid[i] exactly ROM_LAT cycles later.
  assign w_lock_hit = r_lock_vld && req[r_last] && (int'(r_burst_cnt) < MAX_BURST - 1);

  always_comb begin
    gnt = '0;
    if (!reset) gnt = w_lock_hit ? (N_REQ'(1) << r_last) : w_pick;
  end

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) w_win_idx = IW'(i);
    end
  end

  assign w_any    = |gnt;
  assign rom_addr = w_any ? req_addr[w_win_idx*ADDR_W +: ADDR_W] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last      <= IW'(N_REQ - 1);
      r_burst_cnt <= '0;
      r_lock_vld  <= 1'b0;
    end else if (w_any) begin
      r_last      <= w_win_idx;
      r_burst_cnt <= w_lock_hit ? r_burst_cnt + 1'b1 : '0;
      r_lock_vld  <= lock[w_win_idx];
    end else begin
      r_lock_vld  <= 1'b0;
    end
  end

  // Flushing the grant pipe on reset drops in-flight reads silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < ROM_LAT; s++) r_pipe[s] <= '0;
    end else begin
      r_pipe[0] <= gnt;
      for (int s = 1; s < ROM_LAT; s++) r_pipe[s] <= r_pipe[s-1];
    end
  end

  assign rsp_valid = r_pipe[ROM_LAT-1];
  assign rsp_data  = rom_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural arbitration model.
module tb_sprite_rom_arbiter;

  localparam int N     = 4;
  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int LAT   = 2;
  localparam int MB    = 16;
  localparam int BOUND = (N - 1) * MB + 1;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req  = '0;
  logic [N-1:0]    lock = '0;
  logic [AW-1:0]   addr [N];
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_q;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_addr[g*AW +: AW] = addr[g];
  end

  sprite_rom_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT), .MAX_BURST(MB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .lock      (lock),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  // ROM model: returns addr[7:0] after LAT edges
  logic [AW-1:0] rom_s1, rom_s2;
  always @(posedge clk) begin
    rom_s1 <= rom_addr;
    rom_s2 <= rom_s1;
  end
  assign rom_q = rom_s2[7:0];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // scoreboard / behavioural model
  logic [N+7:0]  exp_q[$];
  int            m_last;
  int            m_burst;
  bit            m_lock;
  int            wait_cnt [N];
  int            max_wait = 0;
  int            win;
  bit            locked_win;
  logic [N-1:0]  e_gnt;
  logic [AW-1:0] e_addr;
  logic [N+7:0]  head;

  always @(negedge clk) begin
    if (reset) begin
      check("gnt_in_reset", gnt, 0);
      check("rom_addr_in_reset", rom_addr, 0);
      check("rsp_valid_in_reset", rsp_valid, 0);
      m_last  = N - 1;
      m_burst = 0;
      m_lock  = 0;
      exp_q.delete();
      repeat (LAT) exp_q.push_back('0);
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      win        = -1;
      locked_win = 0;
      if (m_lock && req[m_last] && m_burst < MB - 1) begin
        win        = m_last;
        locked_win = 1;
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (win < 0 && req[(m_last + k) % N]) win = (m_last + k) % N;
        end
      end
      e_gnt  = (win >= 0) ? (N'(1) << win) : '0;
      e_addr = (win >= 0) ? addr[win] : '0;
      check("gnt", gnt, e_gnt);
      check("rom_addr", rom_addr, e_addr);
      head = exp_q.pop_front();
      check("rsp_valid", rsp_valid, head[N+7:8]);
      if (head[N+7:8] != 0) check("rsp_data", rsp_data, head[7:0]);
      exp_q.push_back({e_gnt, e_addr[7:0]});
      if (win >= 0) begin
        m_burst = locked_win ? m_burst + 1 : 0;
        m_lock  = lock[win];
        m_last  = win;
      end else begin
        m_lock = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (e_gnt[i]) begin
          if (wait_cnt[i] + 1 > max_wait) max_wait = wait_cnt[i] + 1;
          wait_cnt[i] = 0;
        end else if (req[i]) begin
          wait_cnt[i]++;
        end else begin
          wait_cnt[i] = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] g_prev;

  initial begin
    for (int i = 0; i < N; i++) addr[i] = '0;
    repeat (3) @(posedge clk);
    #1;

    // reset release: full request, rotation 0,1,2,3,0
    for (int i = 0; i < N; i++) addr[i] = AW'(32'h100 * i + 32'h10 + i);
    reset = 1'b0;
    req   = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("release_gnt", gnt, 1 << (c % 4));
      if (c >= 2) begin
        check("release_rsp_valid", rsp_valid, 1 << (c - 2));
        check("release_rsp_data", rsp_data, 8'h10 + c - 2);
      end
      tick();
    end

    // single requester
    req = '0;
    repeat (3) tick();
    addr[2] = 14'h0A5;
    req     = 4'b0100;
    @(negedge clk);
    check("single_gnt", gnt, 4'b0100);
    check("single_rom_addr", rom_addr, 14'h0A5);
    tick();
    req = '0;
    tick();
    @(negedge clk);
    check("single_rsp_valid", rsp_valid, 4'b0100);
    check("single_rsp_data", rsp_data, 8'hA5);
    tick();

    // burst limit
    addr[1] = 14'h123;
    addr[3] = 14'h345;
    req     = 4'b0010;
    lock    = 4'b0010;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c == 16) check("burst_gnt_other", gnt, 4'b1000);
      else         check("burst_gnt_locked", gnt, 4'b0010);
      tick();
      if (c == 0)  req = 4'b1010;
      if (c == 16) req = 4'b0010;
    end
    req  = '0;
    lock = '0;
    repeat (2) tick();

    // lock drop
    addr[0] = 14'h0C0;
    req     = 4'b0001;
    lock    = 4'b0001;
    @(negedge clk);
    check("lockdrop_first", gnt, 4'b0001);
    tick();
    req = 4'b0111;
    @(negedge clk);
    check("lockdrop_regrant", gnt, 4'b0001);
    tick();
    req  = 4'b0110;
    lock = '0;
    @(negedge clk);
    check("lockdrop_next1", gnt, 4'b0010);
    tick();
    req = 4'b0100;
    @(negedge clk);
    check("lockdrop_next2", gnt, 4'b0100);
    tick();
    req = '0;
    repeat (2) tick();

    // reset mid-flight
    addr[3] = 14'h3C7;
    req     = 4'b1000;
    @(negedge clk);
    check("midflight_gnt", gnt, 4'b1000);
    tick();
    req   = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("midflight_no_rsp", rsp_valid, 0);
      tick();
    end
    req = 4'b1111;
    @(negedge clk);
    check("midflight_prio0", gnt, 4'b0001);
    tick();

    // idle
    req = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        check("idle_gnt", gnt, 0);
        check("idle_rom_addr", rom_addr, 0);
        check("idle_rsp_valid", rsp_valid, 0);
      end
      tick();
    end

    // randomized traffic, requests held until granted
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      g_prev = gnt;
      tick();
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (!(req[i] && !g_prev[i])) begin
          req[i]  = ($urandom_range(0, 99) < 45);
          addr[i] = AW'($urandom_range(0, (1 << AW) - 1));
        end
        lock[i] = ($urandom_range(0, 99) < 70);
      end
    end
    reset = 1'b0;
    req   = '0;
    lock  = '0;
    repeat (4) tick();
    check("starvation_bound_ok", (max_wait <= BOUND), 1);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares the single-port sprite ROM between several sprite-fetch requesters, such as per-layer sprite engines and the background tile fetcher, inside the graphics controller. Each cycle it grants at most one requester, using round-robin priority with optional bounded burst locking. It drives the ROM address and returns the ROM word to the granted requester exactly `ROM_LAT` cycles later, tagged with a one-hot response valid. It sits between the sprite controller datapaths and the `sprite_rom` instance; the ROM itself is unchanged.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..8).
- `ADDR_W`, default 14: sprite ROM address width.
- `DATA_W`, default 8: sprite ROM word width.
- `ROM_LAT`, default 2: clock edges from address presented to valid `rom_q` (1..4).
- `MAX_BURST`, default 16: maximum consecutive locked grants to one requester (≥1).

Ports:
- `clk`  in  1  single clock; everything is on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req`  in  N_REQ  per-requester read request, held until granted.
- `lock`  in  N_REQ  requester asks to keep the grant next cycle (burst).
- `req_addr`  in  N_REQ×ADDR_W  packed per-requester addresses, stable while `req` is high.
- `gnt`  out  N_REQ  one-hot grant, combinational, same cycle as `req`.
- `rom_addr`  out  ADDR_W  address to the ROM; equals the granted `req_addr`, else 0.
- `rom_q`  in  DATA_W  ROM read data.
- `rsp_valid`  out  N_REQ  one-hot, registered; the response belongs to this requester.
- `rsp_data`  out  DATA_W  equals `rom_q`; meaningful only when `rsp_valid` ≠ 0.

## Operation
- **Request handshake.** A requester holds `req`=1 and `req_addr` stable. The read is accepted in the cycle `gnt[i]`=1. The requester may change address or drop `req` on the next cycle.
- **Arbitration.**
  - Priority order starts at `last`+1 (mod `N_REQ`) and wraps.
  - The lowest-index requester in that rotated order with `req`=1 wins.
  - `last` updates to the winner on each granting edge.
  - No requests means no grant; `last` and the burst counter hold.
- **Lock.**
  - If the previous cycle granted `i` with `lock[i]`=1, and `req[i]`=1 now, and `burst_cnt` < `MAX_BURST`−1, then `i` is granted again regardless of rotation.
  - `burst_cnt` increments on a locked regrant and clears on any other grant.
  - When the limit is reached, normal rotation applies, so `i` cannot win if any other requester is pending.
- **Response pipeline.**
  - A `ROM_LAT`-deep shift register carries the one-hot grant vector.
  - `rsp_valid` is the last stage; `rsp_data` is a combinational passthrough of `rom_q`.
  - Back-to-back grants (one per cycle) give back-to-back responses in grant order. Throughput is one read per cycle.
- **Reset.**
  - `reset`=1 forces `gnt`=0 and `rom_addr`=0.
  - `last` is set to `N_REQ`−1, so requester 0 has top priority first.
  - `burst_cnt` is set to 0 and the pipeline is cleared, so `rsp_valid`=0.
  - Reads in flight when reset asserts are discarded and never reported.

## Timing
- Grant latency: 0 cycles. `gnt` and `rom_addr` are combinational from `req`, `lock` and state.
- Response latency: `rsp_valid[i]` is high exactly `ROM_LAT` cycles after the `gnt[i]` cycle, for one cycle per grant.
- Starvation bound: a continuously requesting requester is granted within (`N_REQ`−1)·`MAX_BURST`+1 cycles.
- Simultaneous events:
  - `lock` by a requester that was not granted last cycle is ignored.
  - A locked requester that drops `req` loses the lock; rotation resumes from it.
  - `req` asserting during `reset` is ignored.
  - The first grant after release occurs on the first cycle with `reset`=0.

## Structure
- Shared package `gfx_pkg`: `SPRITE_ADDR_W`, `SPRITE_DATA_W`, `SPRITE_ROM_LAT` constants, plus the `sprite_addr_t` and `sprite_data_t` typedefs. The top level passes these as parameters.
- Sub-module `rr_pick`: combinational rotate-priority-select (`req`, `last` → one-hot winner). It is reusable for future bus arbiters.
- The arbiter holds `last`, `burst_cnt`, the lock-valid flag and the response shift register.

## Test plan
Defaults `N_REQ`=4, `ROM_LAT`=2, `MAX_BURST`=16; the ROM model returns `addr[7:0]`.
- **Reset release.** `req`=4'b1111 with all addresses distinct. Expect grants 0,1,2,3,0 on consecutive cycles. `rsp_valid` follows 2 cycles later with `rsp_data` = the matching address low byte.
- **Single requester.** Only `req[2]`=1 with addr 0x0A5. Expect `gnt`=4'b0100 and `rom_addr`=0x0A5. Two cycles later `rsp_valid`=4'b0100 and `rsp_data`=0xA5.
- **Burst limit.** `req[1]` and `lock[1]` held high, `req[3]`=1. Expect 16 consecutive grants to 1, then `gnt[3]` on cycle 17, then 1 again.
- **Lock drop.** Requester 0 is locked, then `req[0]` drops while 1 and 2 are pending. Expect the next grant to 1, then 2.
- **Reset mid-flight.** Grant requester 3, then assert `reset` the next cycle for 1 cycle. Expect no `rsp_valid` at any time after release until a new grant. After release, requester 0 has priority.
- **Idle.** `req`=0 for 10 cycles. Expect `gnt`=0, `rom_addr`=0 and `rsp_valid`=0 throughout after the pipeline drains.
